easy_fifo_axis_pkt: RTL and testbench

//  Single-clock AXI-Stream FIFO with packet (store-and-forward) mode: m_axis_tvalid rises only once a whole

---
 rtl/easy_fifo_pkg.sv | 11 +
 rtl/easy_fifo_ram.sv | 33 +++
 rtl/easy_fifo_axis_pkt.sv | 165 ++++++++++++++++
 tb/tb_easy_fifo_axis_pkt.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/easy_fifo_pkg.sv
// Shared types and helpers for the packet-mode AXI-Stream FIFO.
package easy_fifo_pkg;

  typedef enum logic {WR_PASS, WR_DROP} wr_state_t;

  // Pointer width: one extra wrap bit above the RAM address.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/easy_fifo_ram.sv
// Simple dual-port RAM, one write port, one registered read port (1-cycle read).
// Read register only updates on re, so the read word holds while re is low.
module easy_fifo_ram #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/easy_fifo_axis_pkt.sv
// Store-and-forward AXIS FIFO: tlast accepted in cycle N -> m_axis_tvalid in N+2; s_axis_tready drops when full.
// EASY_FIFO_PKT_DROP_EN enables rollback of tuser[0]-flagged and oversize packets with a drop_pulse.
module easy_fifo_axis_pkt
  import easy_fifo_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int DEPTH      = 16,
  parameter int USER_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DWIDTH-1:0]      s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  input  logic [USER_WIDTH-1:0]  s_axis_tuser,
  output logic                   s_axis_tready,
  output logic [DWIDTH-1:0]      m_axis_tdata,
  output logic [USER_WIDTH-1:0]  m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic [$clog2(DEPTH):0] pkt_cnt,
  output logic                   drop_pulse
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam int RW = DWIDTH + USER_WIDTH + 1;
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

  wr_state_t     state, state_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [PW-1:0] commit_ptr, commit_nxt;
  logic [PW-1:0] rd_addr;   // next RAM word to move into the output register
  logic [PW-1:0] rd_ptr;    // words handed to the consumer
  logic [PW-1:0] fill;
  logic          full, oversize, wbeat;
  logic          ram_we, pkt_inc, pkt_dec, drop_nxt, drop_q;
  logic          rd_en, m_valid, m_hs;
  logic [RW-1:0] ram_rdata;

  assign fill          = wr_ptr - rd_ptr;
  assign full          = (fill == FULL_LVL);
  assign oversize      = full && (commit_ptr == rd_ptr);
  assign s_axis_tready = (state == WR_DROP) ? 1'b1 : !full;
  assign wbeat         = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WR_PASS;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      drop_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_nxt;
      drop_q     <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    commit_nxt = commit_ptr;
    ram_we     = 1'b0;
    pkt_inc    = 1'b0;
    drop_nxt   = 1'b0;
    case (state)
      WR_PASS: begin
        if (wbeat) begin
          ram_we     = 1'b1;
          wr_ptr_nxt = wr_ptr + ONE;
          if (s_axis_tlast) begin
`ifdef EASY_FIFO_PKT_DROP_EN
            if (s_axis_tuser[0]) begin
              wr_ptr_nxt = commit_ptr;
              drop_nxt   = 1'b1;
            end else begin
              commit_nxt = wr_ptr + ONE;
              pkt_inc    = 1'b1;
            end
`else
            commit_nxt = wr_ptr + ONE;
            pkt_inc    = 1'b1;
`endif
          end
        end else if (oversize) begin
          // Packet larger than the FIFO: nothing can ever drain without action.
`ifdef EASY_FIFO_PKT_DROP_EN
          wr_ptr_nxt = commit_ptr;
          state_nxt  = WR_DROP;
`else
          commit_nxt = wr_ptr;
`endif
        end
      end
      WR_DROP: begin
        if (wbeat && s_axis_tlast) begin
          state_nxt = WR_PASS;
          drop_nxt  = 1'b1;
        end
      end
      default: state_nxt = WR_PASS;
    endcase
  end

  // Output register is the RAM read register; it refills when empty or consumed.
  assign m_hs  = m_valid && m_axis_tready;
  assign rd_en = (commit_ptr != rd_addr) && (!m_valid || m_axis_tready);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr <= '0;
      rd_ptr  <= '0;
      m_valid <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_addr <= rd_addr + ONE;
      end
      if (m_hs) begin
        rd_ptr <= rd_ptr + ONE;
      end
      if (rd_en) begin
        m_valid <= 1'b1;
      end else if (m_axis_tready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign pkt_dec = m_hs && m_axis_tlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (pkt_inc && !pkt_dec) begin
      pkt_cnt <= pkt_cnt + ONE;
    end else if (!pkt_inc && pkt_dec) begin
      pkt_cnt <= pkt_cnt - ONE;
    end
  end

  easy_fifo_ram #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({s_axis_tuser, s_axis_tlast, s_axis_tdata}),
    .re    (rd_en),
    .raddr (rd_addr[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = ram_rdata;
  assign m_axis_tvalid = m_valid;
  assign fifo_cnt      = fill;
  assign drop_pulse    = drop_q;

endmodule

// File: tb/tb_easy_fifo_axis_pkt.sv
// Bench for easy_fifo_axis_pkt: packet table plus directed corner sequences, scoreboard on the master side.
module tb_easy_fifo_axis_pkt;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int UW    = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [4:0]    fifo_cnt;
  logic [4:0]    pkt_cnt;
  logic          drop_pulse;

  always #5 clk = ~clk;

  easy_fifo_axis_pkt #(
    .DWIDTH     (DW),
    .DEPTH      (DEPTH),
    .USER_WIDTH (UW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .fifo_cnt      (fifo_cnt),
    .pkt_cnt       (pkt_cnt),
    .drop_pulse    (drop_pulse)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
  } beat_t;

  typedef struct {
    int            len;
    logic [DW-1:0] base;
    logic          ulast;
    int            exp_fifo;
    int            exp_pkt;
  } vec_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    obs_rd;
  int    checks;
  int    errors;
  int    drop_seen = 0;
  int    stab_err  = 0;
  logic  hold_prev = 1'b0;
  beat_t held;

  // Monitor: records handshaken beats, drop pulses and hold-stability violations.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (drop_pulse) drop_seen++;
      if (hold_prev && m_axis_tvalid &&
          ({m_axis_tdata, m_axis_tuser[0], m_axis_tlast} != held)) stab_err++;
      if (m_axis_tvalid && m_axis_tready)
        obs_q.push_back(beat_t'{m_axis_tdata, m_axis_tuser[0], m_axis_tlast});
      hold_prev = m_axis_tvalid && !m_axis_tready;
      held      = {m_axis_tdata, m_axis_tuser[0], m_axis_tlast};
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic compare_obs();
    beat_t o;
    beat_t e;
    while (obs_rd < obs_q.size()) begin
      o = obs_q[obs_rd];
      obs_rd++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_beat unexpected got d=%h u=%0d l=%0d required none", o.d, o.u, o.l);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL out_beat got d=%h u=%0d l=%0d required d=%h u=%0d l=%0d",
                   o.d, o.u, o.l, e.d, e.u, e.l);
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (n < 300 && !(exp_q.size() == 0 && fifo_cnt == 0 && !m_axis_tvalid)) begin
      @(negedge clk);
      compare_obs();
      n++;
    end
    @(negedge clk);
    compare_obs();
    chk({name, "_pending_beats"}, exp_q.size(), 0);
    chk({name, "_fifo_cnt"}, fifo_cnt, 0);
  endtask

  // Called and returns on a negedge; the beat is taken on the posedge in between.
  task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l, input logic push);
    int n = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout got 0 required 1");
    end
    if (push) exp_q.push_back(beat_t'{d, u, l});
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [DW-1:0] base, input logic ulast, input logic push);
    for (int i = 0; i < len; i++) begin
      send_beat(base + DW'(i), (i == len - 1) ? ulast : logic'(i % 2), i == len - 1, push);
    end
  endtask

  task automatic set_mready(input logic v);
    @(posedge clk);
    #2;
    m_axis_tready = v;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  task automatic check_reset(input string p);
    chk({p, "_m_valid"}, m_axis_tvalid, 0);
    chk({p, "_m_data"}, m_axis_tdata, 0);
    chk({p, "_m_last"}, m_axis_tlast, 0);
    chk({p, "_m_user"}, m_axis_tuser, 0);
    chk({p, "_pkt_cnt"}, pkt_cnt, 0);
    chk({p, "_fifo_cnt"}, fifo_cnt, 0);
    chk({p, "_drop"}, drop_pulse, 0);
    chk({p, "_s_ready"}, s_axis_tready, 1);
  endtask

  initial begin
    vec_t tbl[4];
    int   n;
    int   base;
    tbl[0] = '{2, 32'h0000_1000, 1'b0, 2, 1};
    tbl[1] = '{2, 32'h0000_1100, 1'b0, 4, 2};
    tbl[2] = '{1, 32'h0000_1200, 1'b0, 5, 3};
    tbl[3] = '{4, 32'h0000_1300, 1'b0, 9, 4};

    checks        = 0;
    errors        = 0;
    obs_rd        = 0;
    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset("rst0");

    // T1: no valid before tlast, valid two cycles after tlast acceptance
    set_mready(1'b1);
    send_beat(32'h0000_00A1, 1'b0, 1'b0, 1'b1);
    chk("t1_no_valid_b1", m_axis_tvalid, 0);
    send_beat(32'h0000_00A2, 1'b1, 1'b0, 1'b1);
    chk("t1_no_valid_b2", m_axis_tvalid, 0);
    send_beat(32'h0000_00A3, 1'b0, 1'b1, 1'b1);
    chk("t1_valid_n1", m_axis_tvalid, 0);
    chk("t1_pkt_cnt_1", pkt_cnt, 1);
    @(negedge clk);
    chk("t1_valid_n2", m_axis_tvalid, 1);
    chk("t1_first_data", m_axis_tdata, 32'h0000_00A1);
    wait_drain("t1");
    chk("t1_pkt_cnt_0", pkt_cnt, 0);

    // Packet table with the consumer stalled (first two rows are T2)
    set_mready(1'b0);
    for (int k = 0; k < 4; k++) begin
      send_pkt(tbl[k].len, tbl[k].base, tbl[k].ulast, 1'b1);
      chk($sformatf("vec%0d_fifo_cnt", k), fifo_cnt, tbl[k].exp_fifo);
      chk($sformatf("vec%0d_pkt_cnt", k), pkt_cnt, tbl[k].exp_pkt);
    end
    chk("vec_held_valid", m_axis_tvalid, 1);
    set_mready(1'b1);
    wait_drain("vec");
    chk("vec_pkt_cnt_0", pkt_cnt, 0);

`ifdef EASY_FIFO_PKT_DROP_EN
    // T4: bad-flagged packet is rolled back
    base = drop_seen;
    send_pkt(4, 32'h0000_4000, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    compare_obs();
    chk("t4_drop_pulses", drop_seen - base, 1);
    chk("t4_fifo_cnt", fifo_cnt, 0);
    chk("t4_m_valid", m_axis_tvalid, 0);
    chk("t4_pkt_cnt", pkt_cnt, 0);

    // T5: oversize packet dropped, following good packet delivered
    base = drop_seen;
    send_pkt(20, 32'h0000_5000, 1'b0, 1'b0);
    send_pkt(2, 32'h0000_5100, 1'b0, 1'b1);
    wait_drain("t5");
    chk("t5_drop_pulses", drop_seen - base, 1);
    chk("t5_pkt_cnt", pkt_cnt, 0);
`else
    // T3: oversize packet force-commits and streams through
    set_mready(1'b0);
    for (int i = 0; i < 16; i++) send_beat(32'h0000_3000 + DW'(i), 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!m_axis_tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t3_force_valid", m_axis_tvalid, 1);
    chk("t3_pkt_cnt_open", pkt_cnt, 0);
    chk("t3_fifo_full", fifo_cnt, 16);
    chk("t3_s_ready_full", s_axis_tready, 0);
    set_mready(1'b1);
    send_beat(32'h0000_3010, 1'b0, 1'b1, 1'b1);
    wait_drain("t3");
    chk("t3_pkt_cnt_0", pkt_cnt, 0);

    // tuser[0] on the last beat is plain sideband here
    send_pkt(2, 32'h0000_7000, 1'b1, 1'b1);
    wait_drain("user");
    chk("no_drop_pulses", drop_seen, 0);
`endif

    // T6: reset mid-packet with a complete packet stored
    set_mready(1'b0);
    send_pkt(3, 32'h0000_6000, 1'b0, 1'b1);
    send_beat(32'h0000_6100, 1'b0, 1'b0, 1'b0);
    send_beat(32'h0000_6101, 1'b1, 1'b0, 1'b0);
    chk("t6_pre_pkt_cnt", pkt_cnt, 1);
    base = drop_seen;
    do_reset(2);
    check_reset("t6");
    set_mready(1'b1);
    send_pkt(2, 32'h0000_6200, 1'b0, 1'b1);
    wait_drain("t6_after");
    chk("t6_pkt_cnt", pkt_cnt, 0);
    chk("t6_no_drop", drop_seen - base, 0);

    chk("hold_stable", stab_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
